// File: rtl/bool_matvec_seq_pkg.sv
// Shared types and helpers for the boolean matrix-vector sequencer.
package bool_matvec_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ROW  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic int CLOG2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/bool_row_dot.sv
// One boolean dot product: OR over c of (row[c] AND vec[c]).
module bool_row_dot #(
  parameter int N = 4
) (
  input  logic [N-1:0] row,
  input  logic [N-1:0] vec,
  output logic         dot
);

  assign dot = |(row & vec);

endmodule

// File: rtl/bool_matvec_seq.sv
// Sequencer for u = M^k v over the boolean semiring, one output row per cycle
// through a single shared row-dot unit.
module bool_matvec_seq
  import bool_matvec_seq_pkg::*;
#(
  parameter int N  = 4,
  parameter int KW = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cfg_we,
  input  logic [CLOG2(N)-1:0]   cfg_row,
  input  logic [N-1:0]          cfg_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [N-1:0]          in_vec,
  input  logic [KW-1:0]         in_iter,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [N-1:0]          out_vec,
  output logic                  busy
);

  localparam int             RW   = CLOG2(N);
  localparam logic [RW-1:0]  RMAX = RW'(N - 1);
  localparam logic [RW:0]    NL   = (RW + 1)'(N);

  state_e                 state_q, state_d;
  logic [N-1:0][N-1:0]    mat_q, mat_d;
  logic [N-1:0]           cur_q, cur_d;
  logic [N-1:0]           nxt_q, nxt_d;
  logic [N-1:0]           out_vec_q, out_vec_d;
  logic [KW-1:0]          rem_q, rem_d;
  logic [RW-1:0]          r_q, r_d;
  logic                   dot;
  logic [N-1:0]           pass_vec;

  bool_row_dot #(.N(N)) u_dot (
    .row (mat_q[r_q]),
    .vec (cur_q),
    .dot (dot)
  );

  // The last row's result is still combinational when the pass closes.
  always_comb begin
    pass_vec        = nxt_q;
    pass_vec[N-1]   = dot;
  end

  always_comb begin
    state_d   = state_q;
    mat_d     = mat_q;
    cur_d     = cur_q;
    nxt_d     = nxt_q;
    out_vec_d = out_vec_q;
    rem_d     = rem_q;
    r_d       = r_q;
    case (state_q)
      ST_IDLE: begin
        if (cfg_we && ({1'b0, cfg_row} < NL))
          mat_d[cfg_row] = cfg_data;
        if (in_valid) begin
          cur_d = in_vec;
          rem_d = in_iter;
          r_d   = '0;
          if (in_iter == '0) begin
            out_vec_d = in_vec;
            state_d   = ST_DONE;
          end else begin
            state_d   = ST_ROW;
          end
        end
      end
      ST_ROW: begin
        nxt_d[r_q] = dot;
        if (r_q == RMAX) begin
          cur_d = pass_vec;
          rem_d = rem_q - KW'(1);
          r_d   = '0;
          if (rem_q == KW'(1)) begin
            out_vec_d = pass_vec;
            state_d   = ST_DONE;
          end
        end else begin
          r_d = r_q + RW'(1);
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      mat_q     <= '0;
      cur_q     <= '0;
      nxt_q     <= '0;
      out_vec_q <= '0;
      rem_q     <= '0;
      r_q       <= '0;
    end else begin
      state_q   <= state_d;
      mat_q     <= mat_d;
      cur_q     <= cur_d;
      nxt_q     <= nxt_d;
      out_vec_q <= out_vec_d;
      rem_q     <= rem_d;
      r_q       <= r_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q == ST_ROW) || (state_q == ST_DONE);
  assign out_vec   = out_vec_q;

endmodule
